// File: rtl/hyperbolic_vectoring_pkg.sv
// Shared constants, iteration tables and state type for the hyperbolic
// vectoring CORDIC.
package hyperbolic_cordic_pkg;

   localparam int FRAC_XY   = 14;
   localparam int FRAC_Z    = 13;
   localparam int N_ITER    = 16;
   localparam int GUARD_MAX = 8;

   // Shift per micro-iteration; 4 and 13 appear twice so the hyperbolic
   // sequence converges over the full input range.
   localparam int SHIFT_SCHED [N_ITER] = '{1, 2, 3, 4, 4, 5, 6, 7,
                                           8, 9, 10, 11, 12, 13, 13, 14};

   // atanh(2^-i) with FRAC_Z + GUARD_MAX fractional bits, indexed by i.
   // Entry 0 is never addressed. Narrower guard widths shift these right.
   localparam int ATANH_LUT [16] = '{0, 1151978, 535639, 263522, 131243,
                                     65557, 32771, 16384, 8192, 4096, 2048,
                                     1024, 512, 256, 128, 64};

   // 1/Kh for the schedule above, Q2.14 (1.20750).
   localparam logic [15:0] INV_KH = 16'd19783;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ITER  = 2'd1,
      SCALE = 2'd2,
      OUT   = 2'd3
   } state_t;

endpackage

// File: rtl/hyperbolic_vectoring_if.sv
// Input pair stream and result stream of the vectoring CORDIC, bundled.
// The slave modport is the CORDIC side; master is the surrounding system.
interface hyperbolic_vectoring_if;

   logic        s_axis_cart_tvalid;
   logic        s_axis_cart_tready;
   logic [31:0] s_axis_cart_tdata;
   logic        m_axis_dout_tvalid;
   logic        m_axis_dout_tready;
   logic [31:0] m_axis_dout_tdata;
   logic        m_axis_dout_tuser;

   modport slave (
      input  s_axis_cart_tvalid, s_axis_cart_tdata, m_axis_dout_tready,
      output s_axis_cart_tready, m_axis_dout_tvalid, m_axis_dout_tdata,
             m_axis_dout_tuser
   );

   modport master (
      output s_axis_cart_tvalid, s_axis_cart_tdata, m_axis_dout_tready,
      input  s_axis_cart_tready, m_axis_dout_tvalid, m_axis_dout_tdata,
             m_axis_dout_tuser
   );

endinterface

// File: rtl/hyperbolic_vectoring_step.sv
// One hyperbolic vectoring micro-iteration, purely combinational.
// Direction is chosen to drive y toward zero; x and y use old values.
module hyp_vec_step #(
   parameter int W = 22
) (
   input  logic signed [W-1:0] x_i,
   input  logic signed [W-1:0] y_i,
   input  logic signed [W-1:0] z_i,
   input  logic        [3:0]   shift_i,
   input  logic signed [W-1:0] atanh_i,
   output logic signed [W-1:0] x_o,
   output logic signed [W-1:0] y_o,
   output logic signed [W-1:0] z_o
);

   logic signed [W-1:0] x_sh;
   logic signed [W-1:0] y_sh;

   assign x_sh = x_i >>> shift_i;
   assign y_sh = y_i >>> shift_i;

   // d = +1 when y is negative, otherwise -1
   always_comb begin
      if (y_i[W-1]) begin
         x_o = x_i + y_sh;
         y_o = y_i + x_sh;
         z_o = z_i - atanh_i;
      end else begin
         x_o = x_i - y_sh;
         y_o = y_i - x_sh;
         z_o = z_i + atanh_i;
      end
   end

endmodule

// File: rtl/hyperbolic_vectoring.sv
// Iterative hyperbolic CORDIC, vectoring mode: {sinh, cosh} in,
// {atanh(sinh/cosh), sqrt(cosh^2 - sinh^2)} out. One transaction in flight.
//
//   state | meaning
//   IDLE  | ready for a new pair, s_axis_cart_tready = 1
//   ITER  | 16 micro-iterations, one per cycle, indexed by cnt_q
//   SCALE | gain compensation, rounding, saturation into output register
//   OUT   | result presented, held until downstream accepts
//
// GUARD must be at least 1 (the phase rounding adds half of 2^-GUARD).
module hyperbolic_vectoring
   import hyperbolic_cordic_pkg::*;
#(
   parameter int GUARD = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   hyperbolic_vectoring_if.slave bus
);

   localparam int W  = 16 + 2 + GUARD;
   localparam int PW = W + 17;
   localparam int MS = FRAC_XY + GUARD;
   localparam logic signed [PW-1:0] MAG_MAX = PW'(32767);
   localparam logic signed [W:0]    PH_MAX  = (W+1)'(32767);
   localparam logic signed [W:0]    PH_MIN  = -(W+1)'(32768);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic signed [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic                err_q, err_d;
   logic                tvalid_q, tvalid_d;
   logic [31:0]         tdata_q, tdata_d;
   logic                tuser_q, tuser_d;

   logic [15:0]         cosh_in, sinh_in;
   logic [16:0]         sinh_abs;
   logic [17:0]         lhs5, rhs4;
   logic                range_err;
   logic signed [W-1:0] x_st, y_st, z_st, atanh_k;
   logic [3:0]          shift_k;
   logic signed [PW-1:0] prod, prod_rnd, mag_sh;
   logic signed [W:0]   z_rnd, ph_sh;
   logic [15:0]         mag_sat, ph_sat;

   assign cosh_in = bus.s_axis_cart_tdata[15:0];
   assign sinh_in = bus.s_axis_cart_tdata[31:16];

   assign sinh_abs  = sinh_in[15] ? (17'd0 - {1'b1, sinh_in}) : {1'b0, sinh_in};
   assign lhs5      = ({1'b0, sinh_abs} << 2) + {1'b0, sinh_abs};
   assign rhs4      = {cosh_in, 2'b00};
   assign range_err = cosh_in[15] || (cosh_in == 16'd0) || (lhs5 > rhs4);

   assign shift_k = 4'(SHIFT_SCHED[cnt_q]);
   assign atanh_k = W'(ATANH_LUT[SHIFT_SCHED[cnt_q]] >>> (GUARD_MAX - GUARD));

   hyp_vec_step #(.W(W)) u_step (
      .x_i     (x_q),
      .y_i     (y_q),
      .z_i     (z_q),
      .shift_i (shift_k),
      .atanh_i (atanh_k),
      .x_o     (x_st),
      .y_o     (y_st),
      .z_o     (z_st)
   );

   assign prod     = PW'(x_q) * PW'($signed({1'b0, INV_KH}));
   assign prod_rnd = prod + (PW'(1) <<< (MS - 1));
   assign mag_sh   = prod_rnd >>> MS;
   assign z_rnd    = (W+1)'(z_q) + ((W+1)'(1) <<< (GUARD - 1));
   assign ph_sh    = z_rnd >>> GUARD;

   // Clamp rounded results into their 16-bit output fields
   always_comb begin
      mag_sat = mag_sh[15:0];
      if (mag_sh[PW-1])          mag_sat = 16'h0000;
      else if (mag_sh > MAG_MAX) mag_sat = 16'h7FFF;
      ph_sat = ph_sh[15:0];
      if (ph_sh > PH_MAX)        ph_sat = 16'h7FFF;
      else if (ph_sh < PH_MIN)   ph_sat = 16'h8000;
   end

   // Next-state and datapath update for the sequencing FSM
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      y_d      = y_q;
      z_d      = z_q;
      err_d    = err_q;
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      tuser_d  = tuser_q;
      unique case (state_q)
         IDLE: if (bus.s_axis_cart_tvalid) begin
            x_d     = {{2{cosh_in[15]}}, cosh_in, {GUARD{1'b0}}};
            y_d     = {{2{sinh_in[15]}}, sinh_in, {GUARD{1'b0}}};
            z_d     = '0;
            err_d   = range_err;
            cnt_d   = '0;
            state_d = ITER;
         end
         ITER: begin
            x_d   = x_st;
            y_d   = y_st;
            z_d   = z_st;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(N_ITER - 1)) state_d = SCALE;
         end
         SCALE: begin
            tdata_d  = err_q ? 32'h0 : {ph_sat, mag_sat};
            tuser_d  = err_q;
            tvalid_d = 1'b1;
            state_d  = OUT;
         end
         OUT: if (bus.m_axis_dout_tready) begin
            tvalid_d = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   // State, datapath and output registers; reset aborts any transaction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
         err_q    <= 1'b0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tuser_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         x_q      <= x_d;
         y_q      <= y_d;
         z_q      <= z_d;
         err_q    <= err_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         tuser_q  <= tuser_d;
      end
   end

   assign bus.s_axis_cart_tready = (state_q == IDLE);
   assign bus.m_axis_dout_tvalid = tvalid_q;
   assign bus.m_axis_dout_tdata  = tdata_q;
   assign bus.m_axis_dout_tuser  = tuser_q;

endmodule
